decode_stage: RTL and testbench
===============================

# decode_stage

Decode stage of the core pipeline. It accepts a fetched RV32I instruction and its PC, decodes the integer ALU subset, reads source operands from the register file, and registers `alu_op`, `in0`, `in1`, `rd` and `wb_en` for the execute stage. It is the producer side of the execute stage's operand interface. Valid/ready handshakes are used on both sides; a flush input discards the contents of the stage.

## Interface
- `N_BITS`, default 32: datapath and PC width.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: an instruction is present on the inputs.
- `in_ready` out 1: the stage accepts the instruction this cycle.
- `instr` in 32: instruction word.
- `pc` in N_BITS: PC of `instr`.
- `flush` in 1: discard the held output and any input offered this cycle.
- `rs1_addr`, `rs2_addr` out 5 each: register file read addresses, combinational from `instr`.
- `rs1_data`, `rs2_data` in N_BITS each: register file read data, combinational, same cycle.
- `out_valid` out 1: the output register holds a decoded instruction.
- `out_ready` in 1: the execute stage consumes the output this cycle.
- `alu_op` out `alu_op_t`: registered ALU operation.
- `in0`, `in1` out N_BITS each: registered ALU operands.
- `rd` out 5: destination register.
- `wb_en` out 1: writeback enable.
- `illegal` out 1: the instruction is outside the supported subset.

## Operation
- **Supported opcodes:** OP (0110011), OP-IMM (0010011), LUI (0110111), AUIPC (0010111).
- **OP:** `alu_op` comes from funct3 and funct7; funct7 0100000 is legal only with funct3 000 (SUB) or 101 (SRA). `in0 = rs1_data`, `in1 = rs2_data`.
- **OP-IMM:** `in0 = rs1_data`, `in1 = sign-extended imm[11:0]`.
  - funct3 001 requires funct7 0000000.
  - funct3 101 requires funct7 0000000 (SRLI) or 0100000 (SRAI).
  - Shift immediates use shamt in `in1[4:0]`, upper bits zero.
- **LUI:** `in0 = 0`, `in1 = {instr[31:12], 12'b0}`, `alu_op = ALU_ADD`.
- **AUIPC:** `in0 = pc`, `in1 = {instr[31:12], 12'b0}`, `alu_op = ALU_ADD`.
- **Illegal encodings** (any other opcode or funct combination): `illegal = 1`, `wb_en = 0`, `alu_op = ALU_ADD`, `in0 = in1 = 0`. The instruction still flows downstream.
- **Writeback enable:** `wb_en = 1` for legal instructions with `rd != 0`; otherwise 0.
- **Handshake:**
  - `in_ready = !out_valid || out_ready`.
  - An accept is `in_valid && in_ready && !flush`.
  - On accept, the output register loads and `out_valid` is set.
  - On `out_ready && out_valid` with no accept, `out_valid` clears.
- **Flush** has priority: the next-cycle `out_valid = 0`, and the input offered in the flush cycle is not accepted.
- **Stability:** while `out_valid && !out_ready`, all registered outputs hold stable.

## Timing
- Latency is 1 cycle: an instruction accepted at edge N appears with `out_valid = 1` after edge N.
- Throughput is one instruction per cycle when `out_ready` is held high.
- `rs1_addr`, `rs2_addr` and `in_ready` are combinational.
- Reset values, applied asynchronously: `out_valid = 0`, `alu_op = ALU_ADD`, `in0 = in1 = 0`, `rd = 0`, `wb_en = 0`, `illegal = 0`.
- Reset mid-operation drops the held instruction, with no output on the first cycle after release.
- Simultaneous consume and accept: the register is replaced in the same edge and `out_valid` stays 1.

## Structure
- **Shared package `core_pkg`:**
  - `alu_op_t` enum: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - Opcode constants `OPC_OP`, `OPC_OP_IMM`, `OPC_LUI`, `OPC_AUIPC`.
  - funct7 constants.
- **Sub-module `decode_ctrl`:** purely combinational. Maps `instr` to `alu_op`, operand selects, the immediate, `illegal` and `wb_en`.
- **Top level** holds the operand muxes, handshake logic and pipeline register.

## Test plan
- **ADD:** `add x3,x1,x2` (0x002081B3) with `rs1_data = 5`, `rs2_data = 7`, `out_ready = 1`.
  - `rs1_addr = 1`, `rs2_addr = 2` in the same cycle.
  - Next cycle: `out_valid = 1`, `alu_op = ADD`, `in0 = 5`, `in1 = 7`, `rd = 3`, `wb_en = 1`.
- **Immediates:**
  - `addi x5,x0,-1` (0xFFF00293) → `in1 = 0xFFFFFFFF`, `rd = 5`.
  - `srai x6,x1,4` (0x4040D313) → `alu_op = SRA`, `in1 = 4`.
- **Upper immediates:**
  - LUI 0x123450B7 → `in0 = 0`, `in1 = 0x12345000`.
  - AUIPC 0x00001117 at `pc = 0x100` → `in0 = 0x100`, `in1 = 0x1000`.
- **Backpressure:** `out_ready = 0` for 3 cycles with `in_valid` held.
  - `in_ready = 0` and outputs unchanged during the stall.
  - Raising `out_ready` consumes the held instruction and accepts the next in the same edge.
- **Flush:** `flush = 1` while `out_valid = 1` and `in_valid = 1` → `out_valid = 0` next cycle, and the offered instruction never appears.
- **Illegal and reset:**
  - 0x00000000 → `illegal = 1`, `wb_en = 0`, `in0 = in1 = 0`.
  - `add x0,x1,x2` → `wb_en = 0`.
  - `rst_n` low mid-stream → `out_valid = 0` immediately.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the core pipeline.
//   alu_op_t     - ALU operation selector carried from decode to execute
//   OPC_*        - RV32I major opcodes handled by the decode stage
//   F7_* / F3_*  - funct7 / funct3 field constants
//   sel_a_t      - source select for ALU operand 0 (rs1, zero, pc)
//   sel_b_t      - source select for ALU operand 1 (rs2, immediate, zero)
//   base_alu_op  - funct3 -> ALU op for the non-alternate (funct7 = 0) encodings
package core_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  typedef enum logic [1:0] {
    SEL_A_RS1  = 2'd0,
    SEL_A_ZERO = 2'd1,
    SEL_A_PC   = 2'd2
  } sel_a_t;

  typedef enum logic [1:0] {
    SEL_B_RS2  = 2'd0,
    SEL_B_IMM  = 2'd1,
    SEL_B_ZERO = 2'd2
  } sel_b_t;

  function automatic alu_op_t base_alu_op(input logic [2:0] funct3);
    alu_op_t op;
    case (funct3)
      F3_ADD_SUB: op = ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SRL_SRA: op = ALU_SRL;
      F3_OR:      op = ALU_OR;
      F3_AND:     op = ALU_AND;
      default:    op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/decode_ctrl.sv
// decode_ctrl: purely combinational instruction decoder for the RV32I
// integer ALU subset (OP, OP-IMM, LUI, AUIPC).
//   instr   in  32      instruction word
//   alu_op  out         ALU operation (ALU_ADD for illegal encodings)
//   sel_a   out         operand 0 source
//   sel_b   out         operand 1 source
//   imm     out N_BITS  immediate, already extended/positioned for operand 1
//   illegal out 1       encoding is outside the supported subset
//   wb_en   out 1       legal instruction with rd != x0
// N_BITS must be at least 32.
module decode_ctrl
  import core_pkg::*;
#(
  parameter int N_BITS = 32
) (
  input  logic [31:0]       instr,
  output alu_op_t           alu_op,
  output sel_a_t            sel_a,
  output sel_b_t            sel_b,
  output logic [N_BITS-1:0] imm,
  output logic              illegal,
  output logic              wb_en
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd_field;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign rd_field = instr[11:7];

  always_comb begin
    alu_op  = ALU_ADD;
    sel_a   = SEL_A_ZERO;
    sel_b   = SEL_B_ZERO;
    imm     = '0;
    illegal = 1'b0;

    case (opcode)
      OPC_OP: begin
        sel_a = SEL_A_RS1;
        sel_b = SEL_B_RS2;
        if (funct7 == F7_BASE) begin
          alu_op = base_alu_op(funct3);
        end else if (funct7 == F7_ALT && funct3 == F3_ADD_SUB) begin
          alu_op = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == F3_SRL_SRA) begin
          alu_op = ALU_SRA;
        end else begin
          illegal = 1'b1;
        end
      end

      OPC_OP_IMM: begin
        sel_a  = SEL_A_RS1;
        sel_b  = SEL_B_IMM;
        alu_op = base_alu_op(funct3);
        // Shifts carry a 5-bit shamt; the upper immediate bits are funct7
        // and must not leak into the operand.
        if (funct3 == F3_SLL) begin
          imm = N_BITS'(instr[24:20]);
          if (funct7 != F7_BASE) illegal = 1'b1;
        end else if (funct3 == F3_SRL_SRA) begin
          imm = N_BITS'(instr[24:20]);
          if (funct7 == F7_ALT) begin
            alu_op = ALU_SRA;
          end else if (funct7 != F7_BASE) begin
            illegal = 1'b1;
          end
        end else begin
          imm = N_BITS'($signed(instr[31:20]));
        end
      end

      OPC_LUI: begin
        sel_a = SEL_A_ZERO;
        sel_b = SEL_B_IMM;
        imm   = N_BITS'($signed({instr[31:12], 12'b0}));
      end

      OPC_AUIPC: begin
        sel_a = SEL_A_PC;
        sel_b = SEL_B_IMM;
        imm   = N_BITS'($signed({instr[31:12], 12'b0}));
      end

      default: illegal = 1'b1;
    endcase

    // Illegal instructions still travel downstream as a harmless ADD 0,0.
    if (illegal) begin
      alu_op = ALU_ADD;
      sel_a  = SEL_A_ZERO;
      sel_b  = SEL_B_ZERO;
      imm    = '0;
    end
  end

  assign wb_en = !illegal && (rd_field != 5'd0);

endmodule

// File: rtl/decode_stage.sv
// decode_stage: decode stage of the core pipeline. Decodes one RV32I ALU
// instruction per cycle, reads rs1/rs2 from the register file and registers
// the execute-stage operand bundle.
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   instruction handshake from fetch
//   instr, pc             instruction word and its PC
//   flush                 drop held output and any input offered this cycle
//   rs1_addr, rs2_addr    register file read addresses (combinational)
//   rs1_data, rs2_data    register file read data (same cycle)
//   out_valid / out_ready operand handshake to execute
//   alu_op, in0, in1      registered ALU operation and operands
//   rd, wb_en, illegal    registered destination, writeback enable, illegal flag
//
// Handshake: a transfer happens on an edge where valid && ready. in_ready is
// !out_valid || out_ready, so the register refills in the same edge it is
// drained. While out_valid && !out_ready every output holds. flush beats
// everything: no accept, and out_valid is 0 after the edge.
module decode_stage
  import core_pkg::*;
#(
  parameter int N_BITS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [N_BITS-1:0] pc,
  input  logic              flush,
  output logic [4:0]        rs1_addr,
  output logic [4:0]        rs2_addr,
  input  logic [N_BITS-1:0] rs1_data,
  input  logic [N_BITS-1:0] rs2_data,
  output logic              out_valid,
  input  logic              out_ready,
  output alu_op_t           alu_op,
  output logic [N_BITS-1:0] in0,
  output logic [N_BITS-1:0] in1,
  output logic [4:0]        rd,
  output logic              wb_en,
  output logic              illegal
);

  alu_op_t           dec_alu_op;
  sel_a_t            dec_sel_a;
  sel_b_t            dec_sel_b;
  logic [N_BITS-1:0] dec_imm;
  logic              dec_illegal;
  logic              dec_wb_en;

  logic [N_BITS-1:0] op_a;
  logic [N_BITS-1:0] op_b;
  logic              accept;

  logic              out_valid_d, out_valid_q;
  alu_op_t           alu_op_d, alu_op_q;
  logic [N_BITS-1:0] in0_d, in0_q;
  logic [N_BITS-1:0] in1_d, in1_q;
  logic [4:0]        rd_d, rd_q;
  logic              wb_en_d, wb_en_q;
  logic              illegal_d, illegal_q;

  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];

  decode_ctrl #(
    .N_BITS (N_BITS)
  ) u_decode_ctrl (
    .instr   (instr),
    .alu_op  (dec_alu_op),
    .sel_a   (dec_sel_a),
    .sel_b   (dec_sel_b),
    .imm     (dec_imm),
    .illegal (dec_illegal),
    .wb_en   (dec_wb_en)
  );

  // Operand muxes
  always_comb begin
    op_a = '0;
    case (dec_sel_a)
      SEL_A_RS1: op_a = rs1_data;
      SEL_A_PC:  op_a = pc;
      default:   op_a = '0;
    endcase

    op_b = '0;
    case (dec_sel_b)
      SEL_B_RS2: op_b = rs2_data;
      SEL_B_IMM: op_b = dec_imm;
      default:   op_b = '0;
    endcase
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    out_valid_d = out_valid_q;
    alu_op_d    = alu_op_q;
    in0_d       = in0_q;
    in1_d       = in1_q;
    rd_d        = rd_q;
    wb_en_d     = wb_en_q;
    illegal_d   = illegal_q;

    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // Payload only moves on accept, which keeps it stable during a stall.
    if (accept) begin
      alu_op_d  = dec_alu_op;
      in0_d     = op_a;
      in1_d     = op_b;
      rd_d      = instr[11:7];
      wb_en_d   = dec_wb_en;
      illegal_d = dec_illegal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      alu_op_q    <= ALU_ADD;
      in0_q       <= '0;
      in1_q       <= '0;
      rd_q        <= '0;
      wb_en_q     <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      alu_op_q    <= alu_op_d;
      in0_q       <= in0_d;
      in1_q       <= in1_d;
      rd_q        <= rd_d;
      wb_en_q     <= wb_en_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign alu_op    = alu_op_q;
  assign in0       = in0_q;
  assign in1       = in1_q;
  assign rd        = rd_q;
  assign wb_en     = wb_en_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage. Expected bundles are pushed when the bench
// knows an instruction is accepted and popped when execute consumes one.
module tb_decode_stage;
  import core_pkg::*;

  localparam int W = 75; // {alu_op[3:0], in0[31:0], in1[31:0], rd[4:0], wb_en, illegal}

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        flush;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  alu_op_t     alu_op;
  logic [31:0] in0;
  logic [31:0] in1;
  logic [4:0]  rd;
  logic        wb_en;
  logic        illegal;

  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int stall_cycles = 0;

  decode_stage #(.N_BITS(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc        (pc),
    .flush     (flush),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_op    (alu_op),
    .in0       (in0),
    .in1       (in1),
    .rd        (rd),
    .wb_en     (wb_en),
    .illegal   (illegal)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W-1:0] pack(input alu_op_t op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] r,
                                        input logic w, input logic il);
    return {op, a, b, r, w, il};
  endfunction

  function automatic logic [W-1:0] observed();
    return {alu_op, in0, in1, rd, wb_en, illegal};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %h expected no output", observed());
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (observed() !== e) begin
          errors++;
          $display("FAIL output_bundle: got %h expected %h", observed(), e);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic [31:0] i, input logic [31:0] p,
                      input logic [31:0] r1, input logic [31:0] r2,
                      input logic [W-1:0] e);
    int n;
    in_valid = 1'b1;
    instr    = i;
    pc       = p;
    rs1_data = r1;
    rs2_data = r2;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    stall_cycles += n;
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
    end else begin
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; instr = '0; pc = '0; flush = 1'b0;
    rs1_data = '0; rs2_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (observed() !== pack(ALU_ADD, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0)) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", observed(),
                         pack(ALU_ADD, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0));
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    instr = 32'h002081B3;
    #1;
    checks++;
    if (rs1_addr !== 5'd1 || rs2_addr !== 5'd2) begin
      errors++; $display("FAIL rs_addr: got %0d,%0d expected 1,2", rs1_addr, rs2_addr);
    end
    send(32'h002081B3, 32'h0, 32'd5, 32'd7, pack(ALU_ADD, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0));
    // Latency: accepted at the previous edge, visible now.
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL add_latency: got out_valid=%b expected 1", out_valid);
    end
    // add x0,x1,x2 : no writeback
    send(32'h00208033, 32'h0, 32'd5, 32'd7, pack(ALU_ADD, 32'd5, 32'd7, 5'd0, 1'b0, 1'b0));
    // sub x4,x1,x2
    send(32'h40208233, 32'h0, 32'd9, 32'd4, pack(ALU_SUB, 32'd9, 32'd4, 5'd4, 1'b1, 1'b0));
    drain();
  endtask

  task automatic test_immediates();
    send(32'hFFF00293, 32'h0, 32'h0, 32'h55, pack(ALU_ADD, 32'h0, 32'hFFFFFFFF, 5'd5, 1'b1, 1'b0));
    send(32'h4040D313, 32'h0, 32'h80000000, 32'h55,
         pack(ALU_SRA, 32'h80000000, 32'd4, 5'd6, 1'b1, 1'b0));
    // slli x4,x1,3
    send(32'h00309213, 32'h0, 32'h1, 32'h0, pack(ALU_SLL, 32'h1, 32'd3, 5'd4, 1'b1, 1'b0));
    drain();
  endtask

  task automatic test_upper();
    send(32'h123450B7, 32'h40, 32'hDEADBEEF, 32'h0,
         pack(ALU_ADD, 32'h0, 32'h12345000, 5'd1, 1'b1, 1'b0));
    send(32'h00001117, 32'h100, 32'hDEADBEEF, 32'h0,
         pack(ALU_ADD, 32'h100, 32'h1000, 5'd2, 1'b1, 1'b0));
    drain();
  endtask

  task automatic test_illegal();
    send(32'h00000000, 32'h0, 32'hDEADBEEF, 32'hCAFEF00D,
         pack(ALU_ADD, 32'h0, 32'h0, 5'd0, 1'b0, 1'b1));
    // OP funct3=001 with funct7=0100000
    send(32'h40209233, 32'h0, 32'h11, 32'h22, pack(ALU_ADD, 32'h0, 32'h0, 5'd4, 1'b0, 1'b1));
    // OP-IMM slli with funct7=0100000
    send(32'h40109213, 32'h0, 32'h11, 32'h22, pack(ALU_ADD, 32'h0, 32'h0, 5'd4, 1'b0, 1'b1));
    drain();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    held = pack(ALU_SUB, 32'd9, 32'd4, 5'd4, 1'b1, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h40208233; rs1_data = 32'd9; rs2_data = 32'd4;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_first_ready: got %b expected 1", in_ready);
    end
    exp_q.push_back(held);
    @(posedge clk);
    #1;
    // xor x7,x1,x2 offered and held through the stall
    instr = 32'h0020C3B3; rs1_data = 32'hF0F0; rs2_data = 32'h0FF0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_stall_hs: got in_ready=%b out_valid=%b expected 0,1",
                           in_ready, out_valid);
      end
      checks++;
      if (observed() !== held) begin
        errors++; $display("FAIL bp_stable: got %h expected %h", observed(), held);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release_ready: got %b expected 1", in_ready);
    end
    exp_q.push_back(pack(ALU_XOR, 32'hF0F0, 32'h0FF0, 5'd7, 1'b1, 1'b0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_replace: got out_valid=%b expected 1", out_valid);
    end
    drain();
  endtask

  task automatic test_flush();
    // Held instruction discarded by flush while stalled.
    out_ready = 1'b0;
    send(32'h002081B3, 32'h0, 32'd1, 32'd2, pack(ALU_ADD, 32'd1, 32'd2, 5'd3, 1'b1, 1'b0));
    in_valid = 1'b1; instr = 32'h00520293; rs1_data = 32'd3; flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    void'(exp_q.pop_front());
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_stalled: got out_valid=%b expected 0", out_valid);
    end
    // Flush while the stage could accept: offered instruction must be dropped.
    out_ready = 1'b1;
    send(32'h002081B3, 32'h0, 32'd6, 32'd8, pack(ALU_ADD, 32'd6, 32'd8, 5'd3, 1'b1, 1'b0));
    in_valid = 1'b1; instr = 32'h00A00513; rs1_data = 32'd0; flush = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_in_ready: got %b expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL flush_dropped: got out_valid=%b expected 0 (cycle %0d)",
                           out_valid, k);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [4:0]  r_rd, r_rs1, r_rs2;
    logic [11:0] imm12;
    logic [31:0] a, b;
    stall_cycles = 0;
    out_ready = 1'b1;
    for (int n = 0; n < 24; n++) begin
      r_rd  = 5'($urandom_range(0, 31));
      r_rs1 = 5'($urandom_range(0, 31));
      r_rs2 = 5'($urandom_range(0, 31));
      imm12 = 12'($urandom_range(0, 4095));
      a     = $urandom;
      b     = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        send({imm12, r_rs1, 3'b000, r_rd, 7'b0010011}, 32'h0, a, b,
             pack(ALU_ADD, a, {{20{imm12[11]}}, imm12}, r_rd, r_rd != 5'd0, 1'b0));
      end else begin
        send({7'b0000000, r_rs2, r_rs1, 3'b100, r_rd, 7'b0110011}, 32'h0, a, b,
             pack(ALU_XOR, a, b, r_rd, r_rd != 5'd0, 1'b0));
      end
    end
    checks++;
    if (stall_cycles !== 0) begin
      errors++; $display("FAIL throughput: got %0d stall cycles expected 0", stall_cycles);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(32'h002081B3, 32'h0, 32'd5, 32'd7, pack(ALU_ADD, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0));
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_async_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (observed() !== pack(ALU_ADD, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0)) begin
      errors++; $display("FAIL reset_async_outputs: got %h expected %h", observed(),
                         pack(ALU_ADD, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0));
    end
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release: got out_valid=%b expected 0", out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_immediates();
    test_upper();
    test_illegal();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    drain();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL queue_empty: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
